clock_period_meter: RTL and testbench



---
 rtl/clk_meter_pkg.sv | 12 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/clock_period_meter.sv | 146 ++++++++++++++
 tb/tb_clock_period_meter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meter_pkg;

    // IDLE: no reference rising edge yet; MEASURE: a reference rise has been seen.
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clk_in domain and flags its
// rising and falling edges as single-cycle strobes.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   level_s;

    // Synchronizer chain followed by one history flop for edge detection.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level_s = sync_r[SYNC_STAGES-1];
    assign rise    = level_s & ~prev_r;
    assign fall    = ~level_s & prev_r;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in
// cycles, and flags an input that has stopped producing rising edges.
module clock_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rise_s;
    logic             fall_s;
    meter_state_t     state_r;
    meter_state_t     state_s;
    logic             arm_s;
    logic             cap_high_s;
    logic             report_s;
    logic             stall_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] high_cap_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_time_r;
    logic             valid_r;
    logic             stalled_r;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in  (clk_in),
        .rst     (rst),
        .async_in(sig_in),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath control strobes; a rise beats saturation.
    always_comb begin
        state_s    = state_r;
        arm_s      = 1'b0;
        cap_high_s = 1'b0;
        report_s   = 1'b0;
        stall_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_s = MEASURE;
                    arm_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    report_s = 1'b1;
                end else if (cnt_r == CNT_MAX) begin
                    stall_s = 1'b1;
                    state_s = IDLE;
                end else if (fall_s) begin
                    cap_high_s = 1'b1;
                end else begin
                    state_s = MEASURE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Saturating cycle counter, restarted at 1 on every synchronized rise.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (rise_s) begin
            cnt_r <= CNT_ONE;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= cnt_r;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // High-time capture: cleared on the reference rise, loaded on each fall.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            high_cap_r <= '0;
        end else if (arm_s) begin
            high_cap_r <= '0;
        end else if (cap_high_s) begin
            high_cap_r <= cnt_r;
        end else begin
            high_cap_r <= high_cap_r;
        end
    end

    // Output registers: results and strobe update together; stalled is a level.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            period_r    <= '0;
            high_time_r <= '0;
            valid_r     <= 1'b0;
            stalled_r   <= 1'b0;
        end else begin
            valid_r <= report_s;
            if (report_s) begin
                period_r    <= cnt_r;
                high_time_r <= high_cap_r;
            end else begin
                period_r    <= period_r;
                high_time_r <= high_time_r;
            end
            if (stall_s) begin
                stalled_r <= 1'b1;
            end else if (rise_s) begin
                stalled_r <= 1'b0;
            end else begin
                stalled_r <= stalled_r;
            end
        end
    end

    assign period    = period_r;
    assign high_time = high_time_r;
    assign valid     = valid_r;
    assign stalled   = stalled_r;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: stimulus pushes hand-computed
// expectations, monitors pop and compare on every valid strobe.
module tb_clock_period_meter;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        sig    = 1'b0;
    logic        sig4   = 1'b0;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        valid;
    logic        stalled;
    logic [3:0]  period4;
    logic [3:0]  high_time4;
    logic        valid4;
    logic        stalled4;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_p_q[$];
    logic [15:0] exp_h_q[$];
    logic [3:0]  exp_p4_q[$];
    logic [3:0]  exp_h4_q[$];

    always #10 clk_in = ~clk_in;

    clock_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .sig_in   (sig),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .stalled  (stalled)
    );

    clock_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk_in   (clk_in),
        .rst      (rst),
        .sig_in   (sig4),
        .period   (period4),
        .high_time(high_time4),
        .valid    (valid4),
        .stalled  (stalled4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Main instance monitor.
    always @(negedge clk_in) begin
        logic [15:0] ep;
        logic [15:0] eh;
        if (valid !== 1'b0) begin
            if (exp_p_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: valid=%b period=%0d high_time=%0d, expected no valid (t=%0t)",
                         valid, period, high_time, $time);
            end else begin
                ep = exp_p_q.pop_front();
                eh = exp_h_q.pop_front();
                check("period", 32'(period), 32'(ep));
                check("high_time", 32'(high_time), 32'(eh));
            end
        end
    end

    // Narrow (CNT_W=4) instance monitor.
    always @(negedge clk_in) begin
        logic [3:0] ep;
        logic [3:0] eh;
        if (valid4 !== 1'b0) begin
            if (exp_p4_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid4: valid=%b period=%0d high_time=%0d, expected no valid (t=%0t)",
                         valid4, period4, high_time4, $time);
            end else begin
                ep = exp_p4_q.pop_front();
                eh = exp_h4_q.pop_front();
                check("period4", 32'(period4), 32'(ep));
                check("high_time4", 32'(high_time4), 32'(eh));
            end
        end
    end

    // One period on sig: h cycles high, l cycles low. Entered and left just after a posedge.
    task automatic gen(input int h, input int l, input bit push, input int ep, input int eh);
        if (push) begin
            exp_p_q.push_back(16'(ep));
            exp_h_q.push_back(16'(eh));
        end
        sig = 1'b1;
        repeat (h) @(posedge clk_in);
        #1 sig = 1'b0;
        repeat (l) @(posedge clk_in);
        #1;
    endtask

    task automatic gen4(input int h, input int l, input bit push, input int ep, input int eh);
        if (push) begin
            exp_p4_q.push_back(4'(ep));
            exp_h4_q.push_back(4'(eh));
        end
        sig4 = 1'b1;
        repeat (h) @(posedge clk_in);
        #1 sig4 = 1'b0;
        repeat (l) @(posedge clk_in);
        #1;
    endtask

    initial begin
        // Reset with inputs low, then 20 idle cycles: everything stays 0.
        repeat (3) @(posedge clk_in);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_in);
            #1;
            check("idle_period", 32'(period), 32'd0);
            check("idle_high_time", 32'(high_time), 32'd0);
            check("idle_valid", 32'(valid), 32'd0);
            check("idle_stalled", 32'(stalled), 32'd0);
        end
        check("idle_period4", 32'(period4), 32'd0);
        check("idle_stalled4", 32'(stalled4), 32'd0);

        // Divide-by-4 pattern: 2 high, 2 low; first rise is the reference only.
        gen(2, 2, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) gen(2, 2, 1'b1, 4, 2);
        // Switch to 7 high / 3 low; the first rise still reports the 4/2 period.
        gen(7, 3, 1'b1, 4, 2);
        for (int i = 0; i < 3; i++) gen(7, 3, 1'b1, 10, 7);

        // Reset pulse in the low phase of a locked 10-cycle period.
        exp_p_q.push_back(16'd10);
        exp_h_q.push_back(16'd7);
        sig = 1'b1;
        repeat (7) @(posedge clk_in);
        #1 sig = 1'b0;
        @(posedge clk_in);
        #1 rst = 1'b1;
        @(posedge clk_in);
        #1;
        check("rst_period", 32'(period), 32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_stalled", 32'(stalled), 32'd0);
        rst = 1'b0;
        @(posedge clk_in);
        #1;
        gen(7, 3, 1'b0, 0, 0);
        gen(7, 3, 1'b1, 10, 7);
        gen(7, 3, 1'b1, 10, 7);

        // sig high across reset release: the spurious rise only arms the meter.
        sig = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk_in);
        #1 sig = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        exp_p_q.push_back(16'd9);
        exp_h_q.push_back(16'd5);
        sig = 1'b1;
        repeat (6) @(posedge clk_in);
        #1 sig = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;

        // CNT_W=4: lock at period 6, then hold low until the stall fires.
        gen4(3, 3, 1'b0, 0, 0);
        gen4(3, 3, 1'b1, 6, 3);
        exp_p4_q.push_back(4'd6);
        exp_h4_q.push_back(4'd3);
        sig4 = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 sig4 = 1'b0;
        repeat (14) @(posedge clk_in);
        @(negedge clk_in);
        check("stall_not_yet", 32'(stalled4), 32'd0);
        @(posedge clk_in);
        #1;
        check("stall_set", 32'(stalled4), 32'd1);
        repeat (5) @(posedge clk_in);
        #1;
        check("stall_held", 32'(stalled4), 32'd1);
        check("stall_period_hold", 32'(period4), 32'd6);
        check("stall_high_hold", 32'(high_time4), 32'd3);
        // Two rises 6 cycles apart: first clears stalled, second reports.
        sig4 = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 sig4 = 1'b0;
        check("stall_cleared", 32'(stalled4), 32'd0);
        repeat (3) @(posedge clk_in);
        #1;
        exp_p4_q.push_back(4'd6);
        exp_h4_q.push_back(4'd3);
        sig4 = 1'b1;
        repeat (5) @(posedge clk_in);
        #1 sig4 = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        check("stall_after_resume", 32'(stalled4), 32'd0);

        check("queue_drain", 32'(exp_p_q.size() + exp_p4_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
